// File: rtl/asm18_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : asm18_pkg
//  Description : Shared asm18 core definitions: branch kinds and the condition
//                opcodes consumed by the condition evaluator.
//  Revision    : 1.0  initial release
// ============================================================================
package asm18_pkg;

   // Core-wide defaults
   localparam int WORD_SIZE_DEFAULT   = 18;
   localparam int ADDR_SIZE_DEFAULT   = 16;
   localparam int STACK_DEPTH_DEFAULT = 8;

   // Branch kind carried with a branch-class instruction
   typedef logic [1:0] br_kind_t;

   localparam br_kind_t BR_JUMP = 2'd0;
   localparam br_kind_t BR_CALL = 2'd1;
   localparam br_kind_t BR_RET  = 2'd2;
   localparam br_kind_t BR_RSVD = 2'd3;

   // Condition opcodes evaluated upstream to produce if_ok
   typedef logic [2:0] if_op_t;

   localparam if_op_t IF_ALWAYS = 3'd0;
   localparam if_op_t IF_EQ     = 3'd1;
   localparam if_op_t IF_NE     = 3'd2;
   localparam if_op_t IF_LT     = 3'd3;
   localparam if_op_t IF_GE     = 3'd4;
   localparam if_op_t IF_CARRY  = 3'd5;
   localparam if_op_t IF_NCARRY = 3'd6;
   localparam if_op_t IF_NEVER  = 3'd7;

endpackage
`default_nettype wire

// File: rtl/branch_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_control_if
//  Description : Branch request bundle from execute and PC / status bundle
//                back to fetch. master = execute/fetch side, slave = sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface branch_control_if
   import asm18_pkg::*;
#(
   parameter int ADDR_SIZE   = 16,
   parameter int STACK_DEPTH = 8
);
   localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

   // Requests from execute
   logic                 stall;
   logic                 br_valid;
   br_kind_t             br_kind;
   logic [ADDR_SIZE-1:0] br_pc;
   logic [ADDR_SIZE-1:0] br_target;
   logic                 if_ok;

   // Results to fetch and status
   logic [ADDR_SIZE-1:0] pc;
   logic                 flush;
   logic [DEPTH_W-1:0]   stack_depth;
   logic                 stack_overflow;
   logic                 stack_underflow;
   logic                 bad_kind;

   modport master (
      output stall, br_valid, br_kind, br_pc, br_target, if_ok,
      input  pc, flush, stack_depth, stack_overflow, stack_underflow, bad_kind
   );

   modport slave (
      input  stall, br_valid, br_kind, br_pc, br_target, if_ok,
      output pc, flush, stack_depth, stack_overflow, stack_underflow, bad_kind
   );

endinterface
`default_nettype wire

// File: rtl/return_stack.sv
`default_nettype none
// ============================================================================
//  Module      : return_stack
//  Description : LIFO of return addresses. Push when full and pop when empty
//                are silently ignored. dout always shows the top entry.
//  Revision    : 1.0  initial release
// ============================================================================
module return_stack #(
   parameter int ADDR_SIZE   = 16,
   parameter int STACK_DEPTH = 8,
   localparam int DEPTH_W    = $clog2(STACK_DEPTH) + 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 push,
   input  logic                 pop,
   input  logic [ADDR_SIZE-1:0] din,
   output logic [ADDR_SIZE-1:0] dout,
   output logic                 full,
   output logic                 empty,
   output logic [DEPTH_W-1:0]   depth
);
   localparam int PTR_W = $clog2(STACK_DEPTH);

   logic [ADDR_SIZE-1:0] mem [STACK_DEPTH];
   logic [DEPTH_W-1:0]   count;
   logic [PTR_W-1:0]     top_idx;
   logic                 do_push;
   logic                 do_pop;

   assign full    = (count == DEPTH_W'(STACK_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign top_idx = PTR_W'(count - DEPTH_W'(1));
   assign dout    = mem[top_idx];
   assign depth   = count;

   // Occupancy counter; reset empties the stack even if a push/pop is pending
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (do_push) begin
         count <= count + DEPTH_W'(1);
      end else if (do_pop) begin
         count <= count - DEPTH_W'(1);
      end
   end

   // Storage write at the slot just above the current top; contents need no reset
   always_ff @(posedge clock) begin
      if (!reset && do_push) begin
         mem[count[PTR_W-1:0]] <= din;
      end
   end

endmodule
`default_nettype wire

// File: rtl/branch_control.sv
`default_nettype none
// ============================================================================
//  Module      : branch_control
//  Description : Fetch PC sequencer for the asm18 core. Resolves taken
//                JUMP/CALL/RET branches from execute, redirects the PC one
//                cycle later with a flush pulse, and keeps a return stack.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_control
   import asm18_pkg::*;
#(
   parameter int                   WORD_SIZE   = 18,
   parameter int                   ADDR_SIZE   = 16,
   parameter int                   STACK_DEPTH = 8,
   parameter logic [ADDR_SIZE-1:0] RESET_PC    = '0
) (
   input logic             clock,
   input logic             reset,
   branch_control_if.slave bus
);
   localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

   // Addresses must fit in a core word and the stack must be a power of two
   if ((ADDR_SIZE > WORD_SIZE) || (STACK_DEPTH < 2) ||
       ((STACK_DEPTH & (STACK_DEPTH - 1)) != 0)) begin : g_param_check
      $error("branch_control: unsupported parameter combination");
   end

   logic [ADDR_SIZE-1:0] pc_reg;
   logic                 flush_reg;
   logic                 overflow_reg;
   logic                 underflow_reg;
   logic                 bad_kind_reg;

   logic                 accept;
   logic                 take;
   logic                 jump_take;
   logic                 call_take;
   logic                 ret_take;
   logic                 rsvd_seen;
   logic                 push;
   logic                 pop;
   logic                 redirect;
   logic                 full;
   logic                 empty;
   logic [ADDR_SIZE-1:0] ret_addr;
   logic [ADDR_SIZE-1:0] link_addr;
   logic [ADDR_SIZE-1:0] pc_next;
   logic [DEPTH_W-1:0]   depth;

   // Branch acceptance, stack control and next-PC selection
   always_comb begin
      accept    = bus.br_valid && !bus.stall && !flush_reg;
      take      = accept && bus.if_ok;
      jump_take = take && (bus.br_kind == BR_JUMP);
      call_take = take && (bus.br_kind == BR_CALL);
      ret_take  = take && (bus.br_kind == BR_RET);
      rsvd_seen = accept && (bus.br_kind == BR_RSVD);
      push      = call_take && !full;
      pop       = ret_take && !empty;
      // A CALL with a full stack still redirects; a RET with an empty one does not
      redirect  = jump_take || call_take || pop;
      link_addr = bus.br_pc + ADDR_SIZE'(1);
      pc_next   = pc_reg + ADDR_SIZE'(1);
      if (pop) begin
         pc_next = ret_addr;
      end else if (redirect) begin
         pc_next = bus.br_target;
      end
   end

   // PC, flush pulse and sticky error flags; stall freezes everything but flush
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_reg        <= RESET_PC;
         flush_reg     <= 1'b0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
         bad_kind_reg  <= 1'b0;
      end else if (bus.stall) begin
         flush_reg     <= 1'b0;
      end else begin
         pc_reg        <= pc_next;
         flush_reg     <= redirect;
         overflow_reg  <= overflow_reg  | (call_take && full);
         underflow_reg <= underflow_reg | (ret_take && empty);
         bad_kind_reg  <= bad_kind_reg  | rsvd_seen;
      end
   end

   return_stack #(
      .ADDR_SIZE   (ADDR_SIZE),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_return_stack (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (link_addr),
      .dout  (ret_addr),
      .full  (full),
      .empty (empty),
      .depth (depth)
   );

   assign bus.pc              = pc_reg;
   assign bus.flush           = flush_reg;
   assign bus.stack_depth     = depth;
   assign bus.stack_overflow  = overflow_reg;
   assign bus.stack_underflow = underflow_reg;
   assign bus.bad_kind        = bad_kind_reg;

endmodule
`default_nettype wire

// File: tb/tb_branch_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_control
//  Description : Directed and random bench for branch_control against a
//                queue-based reference model of the PC / return-stack rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_branch_control;
   import asm18_pkg::*;

   localparam int AW = 16;
   localparam int SD = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   branch_control_if #(.ADDR_SIZE(AW), .STACK_DEPTH(SD)) bif ();

   branch_control #(
      .WORD_SIZE   (18),
      .ADDR_SIZE   (AW),
      .STACK_DEPTH (SD),
      .RESET_PC    (16'h0000)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bif.slave)
   );

   // Reference model state
   logic [AW-1:0] m_pc;
   bit            m_flush;
   bit            m_ovf;
   bit            m_unf;
   bit            m_bad;
   logic [AW-1:0] m_stack [$];

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of architectural behaviour, applied to the model state
   task automatic model(input bit r, input bit v, input bit st, input bit ok,
                        input logic [1:0] k, input logic [AW-1:0] bpc,
                        input logic [AW-1:0] tgt);
      bit            acc;
      bit            nf;
      logic [AW-1:0] ra;
      if (r) begin
         m_pc = 16'h0000; m_flush = 0; m_ovf = 0; m_unf = 0; m_bad = 0;
         m_stack.delete();
         return;
      end
      if (st) begin
         m_flush = 0;
         return;
      end
      acc = v && !m_flush;
      nf  = 0;
      if (acc && k == 2'd3) begin
         m_bad = 1;
         m_pc  = m_pc + 16'd1;
      end else if (acc && ok) begin
         if (k == 2'd0) begin
            m_pc = tgt; nf = 1;
         end else if (k == 2'd1) begin
            ra = bpc + 16'd1;
            if (m_stack.size() < SD) m_stack.push_back(ra);
            else m_ovf = 1;
            m_pc = tgt; nf = 1;
         end else begin
            if (m_stack.size() > 0) begin
               m_pc = m_stack.pop_back(); nf = 1;
            end else begin
               m_unf = 1;
               m_pc  = m_pc + 16'd1;
            end
         end
      end else begin
         m_pc = m_pc + 16'd1;
      end
      m_flush = nf;
   endtask

   task automatic check_all();
      chk("pc",        32'(bif.pc),              32'(m_pc));
      chk("flush",     32'(bif.flush),           32'(m_flush));
      chk("depth",     32'(bif.stack_depth),     32'(m_stack.size()));
      chk("overflow",  32'(bif.stack_overflow),  32'(m_ovf));
      chk("underflow", 32'(bif.stack_underflow), 32'(m_unf));
      chk("bad_kind",  32'(bif.bad_kind),        32'(m_bad));
   endtask

   // Drive one cycle of inputs, advance the model at the edge, then compare
   task automatic cyc(input bit r, input bit v, input bit st, input bit ok,
                      input logic [1:0] k, input logic [AW-1:0] bpc,
                      input logic [AW-1:0] tgt);
      rst           = r;
      bif.stall     = st;
      bif.br_valid  = v;
      bif.br_kind   = k;
      bif.br_pc     = bpc;
      bif.br_target = tgt;
      bif.if_ok     = ok;
      @(posedge clk);
      model(r, v, st, ok, k, bpc, tgt);
      #1;
      check_all();
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, BR_JUMP, 16'h0, 16'h0);
   endtask

   bit            r_r, r_v, r_st, r_ok;
   logic [1:0]    r_k;
   int unsigned   sel;

   initial begin
      // Reset, then free-running count
      cyc(1, 0, 0, 0, BR_JUMP, 16'h0, 16'h0);
      chk("reset_pc", 32'(bif.pc), 32'h0);
      chk("reset_depth", 32'(bif.stack_depth), 32'h0);
      for (int i = 1; i < 4; i++) begin
         idle();
         chk("free_pc", 32'(bif.pc), 32'(i));
      end

      // JUMP taken, then not taken
      cyc(0, 1, 0, 1, BR_JUMP, 16'h0003, 16'h0100);
      chk("jump_pc", 32'(bif.pc), 32'h0100);
      chk("jump_flush", 32'(bif.flush), 32'h1);
      idle();
      chk("jump_next", 32'(bif.pc), 32'h0101);
      cyc(0, 1, 0, 0, BR_JUMP, 16'h0101, 16'h0100);
      chk("jump_nt_pc", 32'(bif.pc), 32'h0102);

      // CALL then RET
      cyc(0, 1, 0, 1, BR_CALL, 16'h0010, 16'h0200);
      chk("call_pc", 32'(bif.pc), 32'h0200);
      chk("call_depth", 32'(bif.stack_depth), 32'h1);
      idle();
      cyc(0, 1, 0, 1, BR_RET, 16'h0201, 16'h0000);
      chk("ret_pc", 32'(bif.pc), 32'h0011);
      chk("ret_depth", 32'(bif.stack_depth), 32'h0);
      idle();

      // Nine CALLs overflow an 8-deep stack
      for (int i = 0; i < 9; i++) begin
         cyc(0, 1, 0, 1, BR_CALL, 16'(16'h0030 + i), 16'(16'h0400 + 16 * i));
         idle();
      end
      chk("ovf_depth", 32'(bif.stack_depth), 32'h8);
      chk("ovf_flag", 32'(bif.stack_overflow), 32'h1);

      // Nine RETs: eight LIFO returns, then underflow with no redirect
      for (int i = 0; i < 8; i++) begin
         cyc(0, 1, 0, 1, BR_RET, 16'h0, 16'h0);
         chk("lifo_pc", 32'(bif.pc), 32'(16'h0038 - i));
         idle();
      end
      cyc(0, 1, 0, 1, BR_RET, 16'h0, 16'h0);
      chk("unf_flag", 32'(bif.stack_underflow), 32'h1);
      chk("unf_flush", 32'(bif.flush), 32'h0);
      chk("unf_pc", 32'(bif.pc), 32'h0033);

      // Branch in the flush cycle is ignored
      cyc(0, 1, 0, 1, BR_JUMP, 16'h0, 16'h0500);
      cyc(0, 1, 0, 1, BR_JUMP, 16'h0, 16'h0600);
      chk("flush_ignore_pc", 32'(bif.pc), 32'h0501);

      // Stall holds; same branch accepted once stall drops; stall in flush cycle
      cyc(0, 1, 1, 1, BR_CALL, 16'h0501, 16'h0700);
      chk("stall_pc", 32'(bif.pc), 32'h0501);
      chk("stall_depth", 32'(bif.stack_depth), 32'h0);
      cyc(0, 1, 0, 1, BR_CALL, 16'h0501, 16'h0700);
      chk("unstall_pc", 32'(bif.pc), 32'h0700);
      cyc(0, 0, 1, 0, BR_JUMP, 16'h0, 16'h0);
      chk("stall_flush_drop", 32'(bif.flush), 32'h0);
      chk("stall_flush_pc", 32'(bif.pc), 32'h0700);

      // PC wrap and return-address truncation
      cyc(0, 1, 0, 1, BR_JUMP, 16'h0, 16'hFFFF);
      idle();
      chk("wrap_pc", 32'(bif.pc), 32'h0000);
      cyc(0, 1, 0, 1, BR_CALL, 16'hFFFF, 16'h0900);
      idle();
      cyc(0, 1, 0, 1, BR_RET, 16'h0, 16'h0);
      chk("ret_trunc_pc", 32'(bif.pc), 32'h0000);
      idle();

      // Reserved kind
      cyc(0, 1, 0, 1, BR_RSVD, 16'h0, 16'h0800);
      chk("rsvd_flag", 32'(bif.bad_kind), 32'h1);
      chk("rsvd_flush", 32'(bif.flush), 32'h0);

      // Reset during a CALL empties the stack
      cyc(0, 1, 0, 1, BR_CALL, 16'h0002, 16'h0A00);
      idle();
      cyc(1, 1, 0, 1, BR_CALL, 16'h0A01, 16'h0B00);
      chk("rst_call_depth", 32'(bif.stack_depth), 32'h0);
      chk("rst_call_pc", 32'(bif.pc), 32'h0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         r_r  = ($urandom_range(0, 299) == 0);
         r_v  = ($urandom_range(0, 2) != 0);
         r_st = ($urandom_range(0, 7) == 0);
         r_ok = ($urandom_range(0, 3) != 0);
         sel  = $urandom_range(0, 15);
         r_k  = (sel < 5) ? BR_CALL : (sel < 10) ? BR_RET : (sel < 15) ? BR_JUMP : BR_RSVD;
         cyc(r_r, r_v, r_st, r_ok, r_k, 16'($urandom), 16'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
